// File: rtl/axil_crossbar_wr_route_if.sv
// AXI4-lite write-route bus bundle: command from address decode, slave W/B, and master W/B fan-out.
// slave modport is the routing stage's view; master modport is the driver/observer's view.
interface axil_crossbar_wr_route_if #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  localparam int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  logic [CL_M_COUNT-1:0]  s_wc_select;
  logic                   s_wc_decerr;
  logic                   s_wc_valid;
  logic                   s_wc_ready;

  logic [DATA_WIDTH-1:0]  s_axil_wdata;
  logic [STRB_WIDTH-1:0]  s_axil_wstrb;
  logic                   s_axil_wvalid;
  logic                   s_axil_wready;
  logic [1:0]             s_axil_bresp;
  logic                   s_axil_bvalid;
  logic                   s_axil_bready;

  logic [DATA_WIDTH-1:0]  m_axil_wdata;
  logic [STRB_WIDTH-1:0]  m_axil_wstrb;
  logic [M_COUNT-1:0]     m_axil_wvalid;
  logic [M_COUNT-1:0]     m_axil_wready;
  logic [M_COUNT*2-1:0]   m_axil_bresp;
  logic [M_COUNT-1:0]     m_axil_bvalid;
  logic [M_COUNT-1:0]     m_axil_bready;

  modport slave (
    input  s_wc_select, s_wc_decerr, s_wc_valid,
    output s_wc_ready,
    input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    output s_axil_wready, s_axil_bresp, s_axil_bvalid,
    input  s_axil_bready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready, m_axil_bresp, m_axil_bvalid,
    output m_axil_bready
  );

  modport master (
    output s_wc_select, s_wc_decerr, s_wc_valid,
    input  s_wc_ready,
    output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    input  s_axil_wready, s_axil_bresp, s_axil_bvalid,
    output s_axil_bready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready, m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready
  );
endinterface

// File: rtl/axil_crossbar_wr_route.sv
// Per-slave-port AXI4-lite write route: steers one W beat to the selected master and returns its B.
// Optional AXIL_WR_ROUTE_DECERR_CNT_EN adds a saturating 16-bit decode-error write counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a write command (s_wc_ready high once out of reset)
// ST_WDATA | forwarding (or sinking, on decerr) the single W beat
// ST_WRESP | waiting for the selected master's B response
// ST_BRESP | holding the slave B response until s_axil_bready
module axil_crossbar_wr_route #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic clk,
  input logic rst_n,
  axil_crossbar_wr_route_if.slave bus
`ifdef AXIL_WR_ROUTE_DECERR_CNT_EN
  ,
  output logic [15:0] decerr_count
`endif
);
  localparam int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam logic [CL_M_COUNT:0] M_COUNT_L = (CL_M_COUNT + 1)'(M_COUNT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_BRESP = 2'd3;

  logic [1:0]            state;
  logic [CL_M_COUNT-1:0] sel_q;
  logic                  decerr_q;
  logic                  wc_ready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  sel_bad;
  logic                  w_hs;
  logic                  s_wready_c;
  logic [M_COUNT-1:0]    m_wvalid_c;
  logic [M_COUNT-1:0]    m_bready_c;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  // Out-of-range selects are folded into decerr so they never index a master.
  assign sel_bad = ({1'b0, bus.s_wc_select} >= M_COUNT_L);

  always_comb begin
    s_wready_c = 1'b0;
    m_wvalid_c = '0;
    m_bready_c = '0;
    case (state)
      ST_WDATA: begin
        if (decerr_q) begin
          s_wready_c = 1'b1;
        end else begin
          m_wvalid_c[sel_q] = bus.s_axil_wvalid;
          s_wready_c        = bus.m_axil_wready[sel_q];
        end
      end
      ST_WRESP: begin
        if (!decerr_q) m_bready_c[sel_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hs = bus.s_axil_wvalid && s_wready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      decerr_q   <= 1'b0;
      wc_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wc_ready_q && bus.s_wc_valid) begin
            sel_q      <= bus.s_wc_select;
            decerr_q   <= bus.s_wc_decerr || sel_bad;
            wc_ready_q <= 1'b0;
            state      <= ST_WDATA;
          end else begin
            wc_ready_q <= 1'b1;
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            if (decerr_q) begin
              bresp_q  <= 2'b11;
              bvalid_q <= 1'b1;
              state    <= ST_BRESP;
            end else begin
              state    <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (bus.m_axil_bvalid[sel_q]) begin
            bresp_q  <= bus.m_axil_bresp[{sel_q, 1'b0} +: 2];
            bvalid_q <= 1'b1;
            state    <= ST_BRESP;
          end
        end
        ST_BRESP: begin
          if (bus.s_axil_bready) begin
            bvalid_q   <= 1'b0;
            wc_ready_q <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign w_data = bus.s_axil_wdata;
  assign w_strb = bus.s_axil_wstrb;

  assign bus.s_wc_ready    = wc_ready_q;
  assign bus.s_axil_wready = s_wready_c;
  assign bus.s_axil_bvalid = bvalid_q;
  assign bus.s_axil_bresp  = bresp_q;
  assign bus.m_axil_wdata  = w_data;
  assign bus.m_axil_wstrb  = w_strb;
  assign bus.m_axil_wvalid = m_wvalid_c;
  assign bus.m_axil_bready = m_bready_c;

`ifdef AXIL_WR_ROUTE_DECERR_CNT_EN
  logic [15:0] dec_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= 16'd0;
    end else if (state == ST_WDATA && decerr_q && w_hs && dec_cnt_q != 16'hFFFF) begin
      dec_cnt_q <= dec_cnt_q + 16'd1;
    end
  end

  assign decerr_count = dec_cnt_q;
`endif
endmodule

// File: tb/tb_axil_crossbar_wr_route.sv
// Directed bench for axil_crossbar_wr_route: expected B responses are queued at command time
// and compared when the slave B channel presents them.
module tb_axil_crossbar_wr_route;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic [1:0] exp_q[$];

  axil_crossbar_wr_route_if #(.M_COUNT(4), .DATA_WIDTH(32)) bus ();

`ifdef AXIL_WR_ROUTE_DECERR_CNT_EN
  logic [15:0] decerr_count;
`endif

  axil_crossbar_wr_route #(.M_COUNT(4), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef AXIL_WR_ROUTE_DECERR_CNT_EN
    ,
    .decerr_count (decerr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  task automatic check_b(input string tag);
    logic [1:0] e;
    e = 2'bxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_bvalid"}, 32'(bus.s_axil_bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bus.s_axil_bresp), 32'(e));
  endtask

  task automatic wait_wc_ready(input string tag);
    for (int i = 0; i < 20 && !bus.s_wc_ready; i++) tick();
    check({tag, "_wc_ready_wait"}, 32'(bus.s_wc_ready), 32'd1);
  endtask

  task automatic wait_bvalid(input string tag);
    settle();
    for (int i = 0; i < 20 && !bus.s_axil_bvalid; i++) begin
      tick();
      settle();
    end
    check_b(tag);
  endtask

  // Full write with all readies high; used where only the end result matters.
  task automatic run_write(input string tag, input logic [1:0] sel, input logic dec,
                           input logic [31:0] data, input logic [1:0] mresp);
    wait_wc_ready(tag);
    bus.s_wc_select = sel;
    bus.s_wc_decerr = dec;
    bus.s_wc_valid  = 1'b1;
    exp_q.push_back(dec ? 2'b11 : mresp);
    tick();
    bus.s_wc_valid    = 1'b0;
    bus.s_axil_wdata  = data;
    bus.s_axil_wvalid = 1'b1;
    tick();
    bus.s_axil_wvalid = 1'b0;
    if (!dec) begin
      bus.m_axil_bvalid              = 4'b0000;
      bus.m_axil_bvalid[sel]         = 1'b1;
      bus.m_axil_bresp[sel*2 +: 2]   = mresp;
    end
    wait_bvalid(tag);
    bus.m_axil_bvalid = 4'b0000;
    bus.s_axil_bready = 1'b1;
    tick();
    bus.s_axil_bready = 1'b0;
    settle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.s_wc_select   = '0;
    bus.s_wc_decerr   = 1'b0;
    bus.s_wc_valid    = 1'b0;
    bus.s_axil_wdata  = '0;
    bus.s_axil_wstrb  = '0;
    bus.s_axil_wvalid = 1'b0;
    bus.s_axil_bready = 1'b0;
    bus.m_axil_wready = '0;
    bus.m_axil_bresp  = '0;
    bus.m_axil_bvalid = '0;

    // Reset state
    #3;
    check("rst_wc_ready", 32'(bus.s_wc_ready), 32'd0);
    check("rst_bvalid", 32'(bus.s_axil_bvalid), 32'd0);
    check("rst_bresp", 32'(bus.s_axil_bresp), 32'd0);
    check("rst_wready", 32'(bus.s_axil_wready), 32'd0);
    check("rst_m_wvalid", 32'(bus.m_axil_wvalid), 32'd0);
    check("rst_m_bready", 32'(bus.m_axil_bready), 32'd0);
    #19;
    rst_n = 1'b1;
    tick();
    check("wc_ready_after_rst", 32'(bus.s_wc_ready), 32'd1);

    // Write to master 2; W offered alongside the command must wait for WDATA.
    bus.s_wc_select   = 2'd2;
    bus.s_wc_decerr   = 1'b0;
    bus.s_wc_valid    = 1'b1;
    bus.s_axil_wdata  = 32'hA5A5_0001;
    bus.s_axil_wstrb  = 4'hF;
    bus.s_axil_wvalid = 1'b1;
    bus.m_axil_wready = 4'b1111;
    exp_q.push_back(2'b00);
    settle();
    check("idle_no_wready", 32'(bus.s_axil_wready), 32'd0);
    check("idle_no_m_wvalid", 32'(bus.m_axil_wvalid), 32'd0);
    tick();
    bus.s_wc_valid = 1'b0;
    settle();
    check("t1_wc_ready_low", 32'(bus.s_wc_ready), 32'd0);
    check("t1_m_wvalid", 32'(bus.m_axil_wvalid), 32'b0100);
    check("t1_m_wdata", bus.m_axil_wdata, 32'hA5A5_0001);
    check("t1_m_wstrb", 32'(bus.m_axil_wstrb), 32'hF);
    check("t1_wready", 32'(bus.s_axil_wready), 32'd1);
    tick();
    bus.s_axil_wvalid = 1'b0;
    bus.m_axil_bvalid = 4'b0100;
    bus.m_axil_bresp  = 8'h00;
    settle();
    check("t1_m_bready", 32'(bus.m_axil_bready), 32'b0100);
    check("t1_bvalid_not_yet", 32'(bus.s_axil_bvalid), 32'd0);
    tick();
    bus.m_axil_bvalid = 4'b0000;
    settle();
    check_b("t1");
    bus.s_axil_bready = 1'b1;
    tick();
    bus.s_axil_bready = 1'b0;
    settle();
    check("t1_bvalid_clear", 32'(bus.s_axil_bvalid), 32'd0);
    check("t1_wc_ready_back", 32'(bus.s_wc_ready), 32'd1);

    // Decode error: W sunk locally, DECERR two cycles after the command handshake.
    bus.s_wc_select = 2'd1;
    bus.s_wc_decerr = 1'b1;
    bus.s_wc_valid  = 1'b1;
    exp_q.push_back(2'b11);
    tick();
    bus.s_wc_valid    = 1'b0;
    bus.s_axil_wdata  = 32'h1234_5678;
    bus.s_axil_wvalid = 1'b1;
    settle();
    check("t2_m_wvalid_none", 32'(bus.m_axil_wvalid), 32'd0);
    check("t2_wready", 32'(bus.s_axil_wready), 32'd1);
    tick();
    bus.s_axil_wvalid = 1'b0;
    settle();
    check_b("t2");
    check("t2_m_bready_none", 32'(bus.m_axil_bready), 32'd0);
    bus.s_axil_bready = 1'b1;
    tick();
    bus.s_axil_bready = 1'b0;
    settle();
    check("t2_wc_ready_back", 32'(bus.s_wc_ready), 32'd1);

    // Master 3 SLVERR held under slave backpressure.
    bus.s_wc_select = 2'd3;
    bus.s_wc_decerr = 1'b0;
    bus.s_wc_valid  = 1'b1;
    exp_q.push_back(2'b10);
    tick();
    bus.s_wc_valid    = 1'b0;
    bus.s_axil_wvalid = 1'b1;
    tick();
    bus.s_axil_wvalid = 1'b0;
    bus.m_axil_bvalid = 4'b1000;
    bus.m_axil_bresp  = 8'b10_00_00_00;
    tick();
    bus.m_axil_bvalid = 4'b0000;
    bus.m_axil_bresp  = 8'h00;
    settle();
    check_b("t3");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_bvalid", 32'(bus.s_axil_bvalid), 32'd1);
      check("t3_hold_bresp", 32'(bus.s_axil_bresp), 32'b10);
      check("t3_hold_wc_ready", 32'(bus.s_wc_ready), 32'd0);
      tick();
    end
    bus.s_axil_bready = 1'b1;
    tick();
    bus.s_axil_bready = 1'b0;
    settle();

    // Master 1 responds spuriously while master 0 is selected.
    wait_wc_ready("t4");
    bus.s_wc_select = 2'd0;
    bus.s_wc_valid  = 1'b1;
    exp_q.push_back(2'b01);
    tick();
    bus.s_wc_valid    = 1'b0;
    bus.s_axil_wvalid = 1'b1;
    tick();
    bus.s_axil_wvalid = 1'b0;
    bus.m_axil_bvalid = 4'b0010;
    bus.m_axil_bresp  = 8'b00_00_11_00;
    settle();
    check("t4_m_bready", 32'(bus.m_axil_bready), 32'b0001);
    tick();
    settle();
    check("t4_spurious_ignored", 32'(bus.s_axil_bvalid), 32'd0);
    check("t4_m_bready_held", 32'(bus.m_axil_bready), 32'b0001);
    bus.m_axil_bvalid = 4'b0011;
    bus.m_axil_bresp  = 8'b00_00_11_01;
    tick();
    bus.m_axil_bvalid = 4'b0000;
    settle();
    check_b("t4");
    bus.s_axil_bready = 1'b1;
    tick();
    bus.s_axil_bready = 1'b0;
    settle();

    // Reset while the W beat is being offered to master 2: transaction dropped.
    wait_wc_ready("t5");
    bus.s_wc_select = 2'd2;
    bus.s_wc_valid  = 1'b1;
    tick();
    bus.s_wc_valid    = 1'b0;
    bus.m_axil_wready = 4'b0000;
    bus.s_axil_wvalid = 1'b1;
    settle();
    check("t5_m_wvalid_pre", 32'(bus.m_axil_wvalid), 32'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_wvalid", 32'(bus.m_axil_wvalid), 32'd0);
    check("t5_rst_wready", 32'(bus.s_axil_wready), 32'd0);
    check("t5_rst_wc_ready", 32'(bus.s_wc_ready), 32'd0);
    check("t5_rst_bvalid", 32'(bus.s_axil_bvalid), 32'd0);
    check("t5_rst_m_bready", 32'(bus.m_axil_bready), 32'd0);
    bus.s_axil_wvalid = 1'b0;
    bus.m_axil_wready = 4'b1111;
    #13;
    rst_n = 1'b1;
    run_write("t5_new", 2'd0, 1'b0, 32'hCAFE_0005, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_stale_b", 32'(bus.s_axil_bvalid), 32'd0);
      tick();
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef AXIL_WR_ROUTE_DECERR_CNT_EN
    check("cnt_after_rst", 32'(decerr_count), 32'd0);
    for (int i = 0; i < 3; i++) run_write("cnt_dec", 2'd1, 1'b1, 32'(i), 2'b00);
    run_write("cnt_good", 2'd2, 1'b0, 32'h0000_0BEE, 2'b00);
    check("cnt_three", 32'(decerr_count), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
